fp_div_seq: RTL

Multi-cycle IEEE-754 single-precision divider computing a / b with a valid/ready handshake on both sides. It is the division engine the Newton-Raphson square-root datapath calls for its X/xn step, replacing a combinational divider with a radix-2 restoring iteration. One operation is in flight at a time. Denormals are flushed to zero and results are rounded to nearest-even.

---
 rtl/fp_div_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 binary32 divider (a / b), radix-2 restoring, FTZ, round-to-nearest-even.
// Latency: 28 cycles accept-to-valid on the normal path, 1 cycle for special operands.
// Backpressure: result held in DONE until out_ready; in_ready low while busy, one op in flight.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             state;
    logic [4:0]         count;
    logic [25:0]        rem;
    logic [25:0]        quo;
    logic [23:0]        mb;
    logic signed [9:0]  exp_q;
    logic               sign_q;

    // Operand classification and special-case result selection
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        in_sign;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [3:0]  spec_flags;
    logic signed [9:0] in_exp;

    // Decode incoming operands; zero exponent field is treated as zero (denormals flushed)
    always_comb begin
        a_zero     = (a[30:23] == 8'd0);
        b_zero     = (b[30:23] == 8'd0);
        a_inf      = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf      = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan      = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan      = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        in_sign    = a[31] ^ b[31];
        in_exp     = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
        spec_hit   = 1'b1;
        spec_res   = 32'd0;
        spec_flags = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            // inf divided by any finite value, including zero, stays inf without dz
            spec_res   = {in_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res   = {in_sign, 8'hFF, 23'd0};
            spec_flags = 4'b0100;
        end else if (b_inf || a_zero) begin
            spec_res   = {in_sign, 31'd0};
        end else begin
            spec_hit   = 1'b0;
        end
    end

    // One restoring step: conditional subtract, then shift the partial remainder left
    logic        step_ge;
    logic [25:0] rem_sub;
    logic [25:0] rem_nxt;

    // Compare/subtract for the current quotient bit
    always_comb begin
        step_ge = (rem >= {2'b00, mb});
        rem_sub = step_ge ? (rem - {2'b00, mb}) : rem;
        rem_nxt = {rem_sub[24:0], 1'b0};
    end

    // Normalisation and rounding of the finished quotient
    logic [23:0]       rnd_mant;
    logic              rnd_guard;
    logic              rnd_sticky;
    logic              rnd_inc;
    logic [24:0]       rnd_sum;
    logic [23:0]       fin_mant;
    logic signed [9:0] rnd_exp;
    logic signed [9:0] fin_exp;
    logic [31:0]       rnd_res;
    logic [3:0]        rnd_flags;

    // Quotient lies in (0.5, 2): pick the window by q[25], RNE, then range-check the exponent
    always_comb begin
        if (quo[25]) begin
            rnd_mant   = quo[25:2];
            rnd_guard  = quo[1];
            rnd_sticky = quo[0] | (rem != 26'd0);
            rnd_exp    = exp_q;
        end else begin
            rnd_mant   = quo[24:1];
            rnd_guard  = quo[0];
            rnd_sticky = (rem != 26'd0);
            rnd_exp    = exp_q - 10'sd1;
        end
        rnd_inc = rnd_guard & (rnd_sticky | rnd_mant[0]);
        rnd_sum = {1'b0, rnd_mant} + {24'd0, rnd_inc};
        if (rnd_sum[24]) begin
            fin_mant = 24'h80_0000;
            fin_exp  = rnd_exp + 10'sd1;
        end else begin
            fin_mant = rnd_sum[23:0];
            fin_exp  = rnd_exp;
        end
        if (fin_exp >= 10'sd255) begin
            rnd_res   = {sign_q, 8'hFF, 23'd0};
            rnd_flags = 4'b0010;
        end else if (fin_exp <= 10'sd0) begin
            rnd_res   = {sign_q, 31'd0};
            rnd_flags = 4'b0001;
        end else begin
            rnd_res   = {sign_q, fin_exp[7:0], fin_mant[22:0]};
            rnd_flags = 4'b0000;
        end
    end

    // Control FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 5'd0;
            rem       <= 26'd0;
            quo       <= 26'd0;
            mb        <= 24'd0;
            exp_q     <= 10'sd0;
            sign_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= 32'd0;
            flags     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (spec_hit) begin
                            out       <= spec_res;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem    <= {2'b01, a[22:0], 1'b0} >> 1;
                            mb     <= {1'b1, b[22:0]};
                            quo    <= 26'd0;
                            exp_q  <= in_exp;
                            sign_q <= in_sign;
                            count  <= 5'd0;
                            state  <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    quo <= {quo[24:0], step_ge};
                    rem <= rem_nxt;
                    if (count == 5'd25) begin
                        count <= 5'd0;
                        state <= ROUND;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                ROUND: begin
                    out       <= rnd_res;
                    flags     <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
